// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared constants, parser states and width helper for console_select
package console_pkg;

  localparam logic [7:0] ESC_DEFAULT = 8'h01;
  localparam logic [7:0] ASCII_0     = 8'h30;

  typedef enum logic {
    IDLE     = 1'b0,
    ESC_SEEN = 1'b1
  } state_t;

  // Channel tag width; a single channel bit is kept even for tiny NUM_CH.
  function automatic int chw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous show-ahead FIFO with AW+1 bit wrap pointers
module byte_fifo #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);

  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  // A pop frees the slot this same cycle, so a push into a full FIFO is still accepted.
  assign wr_en = push && (!full || rd_en);

  // Empty reads as zero so the output bus is defined without resetting storage.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/console_select.sv
// rtl/console_select.sv - escape-protocol channel selector feeding a tagged byte FIFO
module console_select
  import console_pkg::*;
#(
  parameter int         NUM_CH     = 4,
  parameter logic [7:0] ESC_BYTE   = ESC_DEFAULT,
  parameter int         FIFO_AW    = 3,
  parameter int         DEFAULT_CH = 0,
  localparam int        CHW        = chw(NUM_CH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx_strobe,
  input  logic [7:0]     rx_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     out_data,
  output logic [CHW-1:0] out_ch,
  output logic [CHW-1:0] sel_ch,
  output logic           overflow,
  output logic           cmd_err
);

  state_t         state;
  state_t         state_nx;
  logic [CHW-1:0] sel_nx;
  logic           push_req;
  logic           err_nx;
  logic           is_digit;
  logic           full;
  logic           empty;
  logic           pop;

  assign is_digit  = (rx_data >= ASCII_0) && (rx_data < ASCII_0 + 8'(NUM_CH));
  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;

  // The pushed byte is always rx_data: a doubled escape forwards ESC_BYTE itself.
  always_comb begin
    state_nx = state;
    sel_nx   = sel_ch;
    push_req = 1'b0;
    err_nx   = 1'b0;
    if (rx_strobe) begin
      case (state)
        IDLE: begin
          if (rx_data == ESC_BYTE) state_nx = ESC_SEEN;
          else                     push_req = 1'b1;
        end
        ESC_SEEN: begin
          state_nx = IDLE;
          if (rx_data == ESC_BYTE) push_req = 1'b1;
          else if (is_digit)       sel_nx   = CHW'(rx_data - ASCII_0);
          else                     err_nx   = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_ch   <= CHW'(DEFAULT_CH);
      overflow <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      sel_ch   <= sel_nx;
      overflow <= push_req && full && !pop;
      cmd_err  <= err_nx;
    end
  end

  byte_fifo #(.W(8 + CHW), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   ({sel_ch, rx_data}),
    .full  (full),
    .pop   (pop),
    .dout  ({out_ch, out_data}),
    .empty (empty)
  );

endmodule
